// File: rtl/calc_stream_controller_if.sv
// Host control and SRAM port bundle for calc_stream_controller.
// master = the controller, slave = host plus memory.
interface calc_stream_controller_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int PACK   = 2,
    parameter int MEM_W  = PACK * DATA_W
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] rd_start;
    logic [ADDR_W-1:0] rd_end;
    logic [ADDR_W-1:0] wr_start;
    logic [ADDR_W-1:0] wr_end;
    logic              read;
    logic [ADDR_W-1:0] r_addr;
    logic [MEM_W-1:0]  r_data;
    logic              write;
    logic [ADDR_W-1:0] w_addr;
    logic [MEM_W-1:0]  w_data;
    logic              busy;
    logic              done;
    logic              ovf;

    // start is only accepted while busy is low. read returns r_data on the
    // following cycle. write commits w_data at w_addr in the same cycle.
    // read and write are never both high.
    modport master (
        input  start, mode, rd_start, rd_end, wr_start, wr_end, r_data,
        output read, r_addr, write, w_addr, w_data, busy, done, ovf
    );

    modport slave (
        output start, mode, rd_start, rd_end, wr_start, wr_end, r_data,
        input  read, r_addr, write, w_addr, w_data, busy, done, ovf
    );
endinterface

// File: rtl/calc_stream_controller.sv
// Streams operand pairs from memory, applies ADD/SUB and writes PACK results per word.
// Optional sticky overflow flag enabled by defining CALC_CTRL_OVF_EN.
module calc_stream_controller #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int PACK   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    calc_stream_controller_if.master  bus,
    output logic [2:0]                dbg_state
);
    localparam int MEM_W  = PACK * DATA_W;
    localparam int LANE_W = $clog2(PACK);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAP   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state, state_next;
    logic              mode_q;
    logic [ADDR_W-1:0] rd_end_q, wr_end_q, rptr, wptr;
    logic [LANE_W-1:0] lane;
    logic [MEM_W-1:0]  pack_buf;
    logic              rd_last;
    logic [DATA_W-1:0] op_a, op_b, res;
    logic              last_lane, last_pair, range_bad;

    assign op_a      = bus.r_data[DATA_W-1:0];
    assign op_b      = bus.r_data[2*DATA_W-1:DATA_W];
    assign res       = mode_q ? (op_a - op_b) : (op_a + op_b);
    assign last_lane = (lane == LANE_W'(PACK - 1));
    // Compared before increment so a range ending at the top address stops cleanly.
    assign last_pair = (rptr == rd_end_q);
    assign range_bad = (bus.rd_end < bus.rd_start) || (bus.wr_end < bus.wr_start);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        bus.read   = 1'b0;
        bus.r_addr = '0;
        bus.write  = 1'b0;
        bus.w_addr = '0;
        bus.w_data = '0;
        bus.busy   = (state != S_IDLE);
        bus.done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = range_bad ? S_DONE : S_READ;
            end
            S_READ: begin
                bus.read   = 1'b1;
                bus.r_addr = rptr;
                state_next = S_CAP;
            end
            S_CAP: begin
                state_next = (last_lane || last_pair) ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                bus.write  = 1'b1;
                bus.w_addr = wptr;
                bus.w_data = pack_buf;
                state_next = (rd_last || (wptr == wr_end_q)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            rd_end_q <= '0;
            wr_end_q <= '0;
            rptr     <= '0;
            wptr     <= '0;
            lane     <= '0;
            pack_buf <= '0;
            rd_last  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        rd_end_q <= bus.rd_end;
                        wr_end_q <= bus.wr_end;
                        rptr     <= bus.rd_start;
                        wptr     <= bus.wr_start;
                        lane     <= '0;
                        pack_buf <= '0;
                        rd_last  <= 1'b0;
                    end
                end
                S_CAP: begin
                    for (int k = 0; k < PACK; k++) begin
                        if (lane == LANE_W'(k)) pack_buf[k*DATA_W +: DATA_W] <= res;
                    end
                    rptr    <= rptr + 1'b1;
                    rd_last <= last_pair;
                    lane    <= (last_lane || last_pair) ? '0 : lane + 1'b1;
                end
                S_WRITE: begin
                    wptr     <= wptr + 1'b1;
                    pack_buf <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef CALC_CTRL_OVF_EN
    logic ovf_q;
    logic carry;

    // A wrapped sum is smaller than either addend; a borrow means op_b exceeded op_a.
    assign carry   = mode_q ? (op_a < op_b) : (res < op_a);
    assign bus.ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state == S_IDLE) && bus.start) begin
            ovf_q <= 1'b0;
        end else if ((state == S_CAP) && carry) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
